m_mem_ctrl: RTL

M_MEM_CTRL -- requirements
Module: M_MemCtrl

---
 rtl/m_mem_ctrl_pkg.sv | 26 ++
 rtl/m_mem_ctrl_timer.sv | 37 +++
 rtl/m_mem_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/m_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory controller.
//   - FSM state encoding
//   - default bus timeout
//   - store-size codes used by the byte-enable generator
//   - word alignment helper for the memory-side address
package m_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

  localparam int TIMEOUT_DEF = 16;

  // Store-size codes shared with the byte-enable generator.
  localparam logic [1:0] DM_SW = 2'b00;
  localparam logic [1:0] DM_SH = 2'b01;
  localparam logic [1:0] DM_SB = 2'b10;

  // Memory is word-addressed on the bus side; drop the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/m_mem_ctrl_timer.sv
// Bus timeout counter for the memory controller.
// Ports:
//   clk     - clock
//   reset   - asynchronous active-low reset
//   en      - count one BUSY cycle
//   clr     - return the count to zero (has priority over en)
//   expired - count has reached TIMEOUT-1
module m_mem_ctrl_timer
  import m_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // Hold at the terminal value; the controller leaves BUSY on expiry anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/m_mem_ctrl.sv
// MEM-stage memory controller: accepts one load/store from the pipeline,
// runs a req/ack handshake with memory, and pulses done on completion.
// A bus that does not acknowledge within TIMEOUT cycles ends the access
// with bus_err.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   req_valid, req_we - pipeline request and store(1)/load(0)
//   addr, wdata       - byte address, lane-shifted store data
//   byteen            - store byte enables (ignored for loads)
//   flush             - blocks acceptance of a new request in IDLE
//   stall             - freeze the pipeline
//   rdata             - captured load word
//   done, bus_err     - one-cycle completion pulse, timeout flag
//   mem_*             - memory-side handshake
module m_mem_ctrl
  import m_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  mem_state_t r_state;
  mem_state_t w_state_nxt;

  logic        w_accept;
  logic        w_bypass;
  logic        w_busy;
  logic        w_expired;
  logic        r_err;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_byteen;
  logic [31:0] r_rdata;

  assign w_busy   = (r_state == ST_BUSY);
  assign w_accept = (r_state == ST_IDLE) && req_valid && !flush;
  // A store that writes no bytes has nothing to send to memory.
  assign w_bypass = w_accept && req_we && (byteen == 4'b0000);

  m_mem_ctrl_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (w_busy),
    .clr     (!w_busy),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ack is checked before expiry so a same-cycle ack wins.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_bypass) begin
          w_state_nxt = ST_DONE;
        end else if (w_accept) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack || w_expired) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req = w_busy;
    done    = (r_state == ST_DONE);
    bus_err = (r_state == ST_DONE) && r_err;
    stall   = (w_accept && !w_bypass) || w_busy;
  end

  // Request latch and load-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_byteen <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err <= 1'b0;
      end
      if (w_accept && !w_bypass) begin
        r_mem_we     <= req_we;
        r_mem_addr   <= word_align(addr);
        r_mem_wdata  <= wdata;
        r_mem_byteen <= req_we ? byteen : 4'b1111;
      end
      if (w_busy) begin
        if (mem_ack) begin
          if (!r_mem_we) begin
            r_rdata <= mem_rdata;
          end
        end else if (w_expired) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_byteen = r_mem_byteen;
  assign rdata      = r_rdata;

endmodule
